// File: rtl/trans_pkg.sv
`default_nettype none
// =============================================================================
// Module  : trans_pkg
// Brief   : Shared widths, field positions and FSM encoding for trans_arbiter.
// Revision: 1.0  initial release
// =============================================================================
package trans_pkg;

    localparam int TRANS_W         = 128;
    localparam int BIT_BLOCK_START = 9;

    typedef logic [TRANS_W-1:0] trans_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2,
        WAIT  = 2'd3
    } trans_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/trans_fifo.sv
`default_nettype none
// =============================================================================
// Module  : trans_fifo
// Brief   : Synchronous first-word-fall-through FIFO for one transaction source.
// Revision: 1.0  initial release
// =============================================================================
module trans_fifo
    import trans_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_i,
    input  trans_t push_data_i,
    input  logic   pop_i,
    output trans_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    trans_t      mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic        w_do_push;
    logic        w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/trans_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : trans_arbiter
// Brief   : Buffers transactions per source and issues one at a time to an
//           idle validator; round-robin, or strict priority with
//           TRANS_ARB_PRIO_EN defined.
// Revision: 1.0  initial release
// =============================================================================
module trans_arbiter
    import trans_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*TRANS_W-1:0] src_data_i,
    input  logic [NUM_SRC-1:0]         src_valid_i,
    output logic [NUM_SRC-1:0]         src_ready_o,
    output logic [TRANS_W-1:0]         vld_data_o,
    output logic                       vld_valid_o,
    input  logic                       vld_idle_i,
    output logic [31:0]                issued_cnt_o
);

    localparam int                 PTR_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [PTR_W-1:0]   C_LAST_SRC = PTR_W'(NUM_SRC - 1);
    localparam logic [1:0]         ST_ARB     = ARB;
    localparam logic [1:0]         ST_ISSUE   = ISSUE;
    localparam logic [1:0]         ST_GAP     = GAP;
    localparam logic [1:0]         ST_WAIT    = WAIT;

    logic [NUM_SRC-1:0] w_full;
    logic [NUM_SRC-1:0] w_empty;
    logic [NUM_SRC-1:0] w_pop;
    trans_t             w_head [NUM_SRC];

    logic               w_grant_valid;
    logic [PTR_W-1:0]   w_grant_idx;
    logic               w_issue;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    trans_t             vld_data_q;
    trans_t             vld_data_d;
    logic               vld_valid_q;
    logic               vld_valid_d;
    logic [31:0]        issued_cnt_q;
    logic [31:0]        issued_cnt_d;

    // FIFOs are empty right after reset, so !full gives all-ones on release.
    assign src_ready_o = rst ? '0 : ~w_full;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            assign w_pop[s] = w_issue && (w_grant_idx == PTR_W'(s));

            trans_fifo #(
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .push_i      (src_valid_i[s] & src_ready_o[s]),
                .push_data_i (src_data_i[s*TRANS_W +: TRANS_W]),
                .pop_i       (w_pop[s]),
                .head_o      (w_head[s]),
                .full_o      (w_full[s]),
                .empty_o     (w_empty[s])
            );
        end
    endgenerate

`ifdef TRANS_ARB_PRIO_EN
    // Descending scan: the lowest non-empty index is written last and wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (!w_empty[i]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = PTR_W'(i);
            end
        end
    end
`else
    localparam logic [PTR_W:0] C_NUM_SRC = (PTR_W+1)'(NUM_SRC);
    logic [PTR_W:0] w_cand;

    // Descending scan from rr_ptr: the candidate nearest rr_ptr wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            w_cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (w_cand >= C_NUM_SRC) begin
                w_cand = w_cand - C_NUM_SRC;
            end
            if (!w_empty[w_cand[PTR_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_cand[PTR_W-1:0];
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        vld_data_d   = vld_data_q;
        vld_valid_d  = 1'b0;
        issued_cnt_d = issued_cnt_q;
        w_issue      = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (vld_idle_i && w_grant_valid) begin
                    w_issue     = 1'b1;
                    vld_valid_d = 1'b1;
                    vld_data_d  = w_head[w_grant_idx];
`ifdef TRANS_ARB_PRIO_EN
                    rr_ptr_d    = '0;
`else
                    rr_ptr_d    = (w_grant_idx == C_LAST_SRC) ? '0
                                                              : w_grant_idx + PTR_W'(1);
`endif
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                issued_cnt_d = issued_cnt_q + 32'd1;
                state_d      = ST_GAP;
            end
            // The validator only drops idle one cycle after the strobe.
            ST_GAP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (vld_idle_i) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ARB;
            rr_ptr_q     <= '0;
            vld_data_q   <= '0;
            vld_valid_q  <= 1'b0;
            issued_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            vld_data_q   <= vld_data_d;
            vld_valid_q  <= vld_valid_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign vld_data_o   = vld_data_q;
    assign vld_valid_o  = vld_valid_q;
    assign issued_cnt_o = issued_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_trans_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_trans_arbiter
// Brief   : Self-checking bench for trans_arbiter: vector table, directed
//           corner sequences and random traffic against a queue-based model.
// Revision: 1.0  initial release
// =============================================================================
module tb_trans_arbiter;
    import trans_pkg::*;

    localparam int NS    = 2;
    localparam int DEPTH = 8;

    logic                  clk       = 1'b0;
    logic                  rst       = 1'b1;
    logic [NS*TRANS_W-1:0] src_data  = '0;
    logic [NS-1:0]         src_valid = '0;
    logic [NS-1:0]         src_ready;
    trans_t                vld_data;
    logic                  vld_valid;
    logic                  idle      = 1'b0;
    logic [31:0]           issued_cnt;

    always #5 clk = ~clk;

    trans_arbiter #(
        .NUM_SRC    (NS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_data_i   (src_data),
        .src_valid_i  (src_valid),
        .src_ready_o  (src_ready),
        .vld_data_o   (vld_data),
        .vld_valid_o  (vld_valid),
        .vld_idle_i   (idle),
        .issued_cnt_o (issued_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per source plus "validator seen idle" state.
    trans_t      mq0[$];
    trans_t      mq1[$];
    int          m_ptr    = 0;
    logic [31:0] m_cnt    = '0;
    int          m_last_g = -100;
    bit          m_seen   = 1'b1;
    int          cyc      = 0;
    bit          p_rst    = 1'b1;
    bit          p_idle   = 1'b0;
    logic [1:0]  p_push   = '0;
    trans_t      p_d0     = '0;
    trans_t      p_d1     = '0;

    // Validator emulation and observed issue log.
    bit          auto_idle   = 1'b0;
    bit          rand_busy   = 1'b0;
    bit          drop_pend   = 1'b0;
    int          busy        = 0;
    int          scyc        = 0;
    int          last_strobe = -100;
    int          seq         = 0;
    int          act_src[$];

    typedef struct {
        bit          rst;
        logic [1:0]  vld;
        trans_t      data;
        bit          idle;
        bit          e_vld;
        trans_t      e_data;
        logic [1:0]  e_rdy;
        logic [31:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qlen(input int s);
        return (s == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic int pick();
`ifdef TRANS_ARB_PRIO_EN
        return (mq0.size() > 0) ? 0 : 1;
`else
        for (int i = 0; i < NS; i++) begin
            int s;
            s = (m_ptr + i) % NS;
            if (qlen(s) > 0) return s;
        end
        return 0;
`endif
    endfunction

    function automatic trans_t mk(input int s);
        seq++;
        return {8'(s), 24'(seq), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at the falling edge: judges what the preceding rising edge did.
    task automatic monitor();
        bit         exp_v;
        trans_t     exp_d;
        int         g;
        logic [1:0] exp_rdy;
        cyc++;
        if (p_rst) begin
            mq0.delete();
            mq1.delete();
            m_ptr    = 0;
            m_cnt    = '0;
            m_seen   = 1'b1;
            m_last_g = -100;
            chk("rst_valid", vld_valid, 0);
            chk("rst_data", vld_data, 0);
            chk("rst_cnt", issued_cnt, 0);
        end else begin
            chk("issued_cnt", issued_cnt, m_cnt);
            exp_v = p_idle && m_seen && (mq0.size() + mq1.size() > 0);
            chk("strobe", vld_valid, exp_v);
            if (exp_v) begin
                g = pick();
                if (g == 0) exp_d = mq0.pop_front();
                else        exp_d = mq1.pop_front();
                chk("issue_data", vld_data, exp_d);
                m_cnt    = m_cnt + 32'd1;
                m_last_g = cyc;
                m_seen   = 1'b0;
                m_ptr    = (g + 1) % NS;
            end
            // Validator busy window: idle must be seen from the 3rd edge after a grant.
            if (cyc >= m_last_g + 3 && p_idle) m_seen = 1'b1;
            if (p_push[0]) mq0.push_back(p_d0);
            if (p_push[1]) mq1.push_back(p_d1);
        end
        exp_rdy[0] = !rst && (mq0.size() < DEPTH);
        exp_rdy[1] = !rst && (mq1.size() < DEPTH);
        chk("src_ready", src_ready, exp_rdy);
        p_rst  = rst;
        p_idle = idle;
        p_push = src_valid & exp_rdy;
        p_d0   = src_data[127:0];
        p_d1   = src_data[255:128];
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        scyc++;
        if (vld_valid) begin
            act_src.push_back(int'(vld_data[127:120]));
            if (last_strobe >= 0) chk("strobe_gap_ge4", (scyc - last_strobe) >= 4, 1'b1);
            last_strobe = scyc;
        end
        if (rst) last_strobe = -100;
        if (auto_idle) begin
            if (drop_pend) begin
                idle      = 1'b0;
                busy      = rand_busy ? $urandom_range(1, 12) : 10;
                drop_pend = 1'b0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) idle = 1'b1;
            end
            if (vld_valid) drop_pend = 1'b1;
        end
    endtask

    task automatic set_auto(input bit on);
        auto_idle = on;
        drop_pend = 1'b0;
        busy      = 0;
        if (on) idle = 1'b1;
    endtask

    task automatic push_word(input int s, input trans_t w);
        bit acc;
        bit done;
        done = 1'b0;
        src_valid[s] = 1'b1;
        src_data[s*TRANS_W +: TRANS_W] = w;
        for (int t = 0; t < 300 && !done; t++) begin
            acc = src_ready[s];
            step();
            done = acc;
        end
        src_valid[s] = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: src %0d word never accepted", s);
        end
    endtask

    task automatic drain();
        bit done;
        done      = 1'b0;
        src_valid = '0;
        set_auto(1'b1);
        for (int t = 0; t < 500 && !done; t++) begin
            step();
            done = (mq0.size() == 0) && (mq1.size() == 0) && (t > 8);
        end
        for (int t = 0; t < 16; t++) step();
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: queues not emptied");
        end
    endtask

    initial begin
        vec_t   tbl[10];
        trans_t w1;
        trans_t w2;
        int     exp_order[6];

        w1 = 128'hA000_0000_0000_0000_0000_0000_0000_0001;
        w2 = 128'h015A_0000_0000_0000_0000_0000_0000_0200;
        tbl[0] = '{1'b1, 2'b00, '0, 1'b1, 1'b0, '0, 2'b00, 32'd0};
        tbl[1] = '{1'b0, 2'b00, '0, 1'b1, 1'b0, '0, 2'b11, 32'd0};
        tbl[2] = '{1'b0, 2'b01, w1, 1'b1, 1'b0, '0, 2'b11, 32'd0};
        tbl[3] = '{1'b0, 2'b00, '0, 1'b1, 1'b1, w1, 2'b11, 32'd0};
        tbl[4] = '{1'b0, 2'b00, '0, 1'b1, 1'b0, w1, 2'b11, 32'd1};
        tbl[5] = '{1'b0, 2'b00, '0, 1'b0, 1'b0, w1, 2'b11, 32'd1};
        tbl[6] = '{1'b0, 2'b10, w2, 1'b0, 1'b0, w1, 2'b11, 32'd1};
        tbl[7] = '{1'b0, 2'b00, '0, 1'b1, 1'b0, w1, 2'b11, 32'd1};
        tbl[8] = '{1'b0, 2'b00, '0, 1'b1, 1'b1, w2, 2'b11, 32'd1};
        tbl[9] = '{1'b0, 2'b00, '0, 1'b1, 1'b0, w2, 2'b11, 32'd2};

        // Single issue latency, bit-exact forwarding and reset values.
        for (int i = 0; i < 10; i++) begin
            rst       = tbl[i].rst;
            src_valid = tbl[i].vld;
            src_data  = {tbl[i].data, tbl[i].data};
            idle      = tbl[i].idle;
            step();
            chk($sformatf("vec%0d_valid", i), vld_valid, tbl[i].e_vld);
            chk($sformatf("vec%0d_data", i), vld_data, tbl[i].e_data);
            chk($sformatf("vec%0d_ready", i), src_ready, tbl[i].e_rdy);
            chk($sformatf("vec%0d_cnt", i), issued_cnt, tbl[i].e_cnt);
        end
        src_valid = '0;

        // Both sources loaded, validator busy 10 cycles per transaction.
        set_auto(1'b1);
        act_src.delete();
        for (int k = 0; k < 3; k++) begin
            src_valid = 2'b11;
            src_data  = {mk(1), mk(0)};
            step();
        end
        src_valid = '0;
        for (int t = 0; t < 120; t++) step();
        chk("t2_strobes", act_src.size(), 6);
`ifdef TRANS_ARB_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        for (int k = 0; k < 6 && k < act_src.size(); k++) begin
            chk($sformatf("t2_order%0d", k), act_src[k], exp_order[k]);
        end

        // Fill src1 with the validator busy, then drain.
        drain();
        set_auto(1'b0);
        idle = 1'b0;
        act_src.delete();
        for (int k = 0; k < 8; k++) push_word(1, mk(1));
        src_valid[1] = 1'b1;
        src_data[255:128] = mk(1);
        for (int t = 0; t < 3; t++) step();
        chk("t3_full_ready", src_ready[1], 1'b0);
        chk("t3_no_issue", act_src.size(), 0);
        set_auto(1'b1);
        push_word(1, src_data[255:128]);
        for (int t = 0; t < 140; t++) step();
        chk("t3_strobes", act_src.size(), 9);

        // Idle held high continuously: back-to-back spacing.
        drain();
        set_auto(1'b0);
        idle = 1'b1;
        for (int t = 0; t < 120; t++) begin
            src_valid = 2'($urandom_range(0, 3));
            src_data  = {mk(1), mk(0)};
            step();
        end
        src_valid = '0;
        for (int t = 0; t < 80; t++) step();

        // Reset while waiting with two words queued.
        drain();
        set_auto(1'b0);
        idle = 1'b1;
        for (int k = 0; k < 3; k++) push_word(0, mk(0));
        idle = 1'b0;
        for (int t = 0; t < 4; t++) step();
        rst = 1'b1;
        step();
        chk("t5_ready_in_rst", src_ready, 2'b00);
        step();
        rst = 1'b0;
        step();
        chk("t5_cnt_cleared", issued_cnt, 0);
        chk("t5_ready_after", src_ready, 2'b11);
        for (int t = 0; t < 5; t++) step();
        idle = 1'b1;
        act_src.delete();
        for (int t = 0; t < 6; t++) step();
        chk("t5_no_strobe", act_src.size(), 0);
        push_word(0, mk(0));
        for (int t = 0; t < 4; t++) step();
        chk("t5_one_strobe", act_src.size(), 1);

        // Random traffic, alternating validator behaviour, one mid-run reset.
        drain();
        for (int t = 0; t < 1200; t++) begin
            if (t % 200 == 0) begin
                set_auto((t / 200) % 2 == 0);
                rand_busy = 1'b1;
            end
            if (!auto_idle) idle = 1'($urandom_range(0, 1));
            rst       = (t >= 700 && t < 702);
            src_valid = 2'($urandom_range(0, 3));
            src_data  = {mk(1), mk(0)};
            step();
        end
        rst = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
